mem_initiator: RTL
==================

// Module: mem_initiator
// PURPOSE
//  Bus initiator for the 32x8 synchronous memory on mem_intf. Accepts single or burst
//  read/write commands on a valid/ready port and drives read/write/addr/data_in to the memory.
//  Returns read data on a response port; the memory returns data one clock after the read strobe.
//  Sits between a test sequencer or CPU-side agent and the memory responder.
// PARAMETERS
//  ADDR_W  5  memory address width; depth = 2**ADDR_W words
//  DATA_W  8  memory data width
// PORTS
//  clk          in   1       single clock; all state changes on posedge clk
//  rst_n        in   1       asynchronous, active-low reset
//  cmd_valid    in   1       command offered
//  cmd_ready    out  1       command accepted when cmd_valid && cmd_ready at posedge
//  cmd_write    in   1       1 = write burst, 0 = read burst
//  cmd_addr     in   ADDR_W  start address
//  cmd_len      in   ADDR_W  burst beats minus one (0 = 1 beat, 31 = 32 beats)
//  cmd_wdata    in   DATA_W  write seed; beat k writes cmd_wdata + k (mod 2**DATA_W)
//  rsp_valid    out  1       one read-data beat valid this cycle (no backpressure)
//  rsp_addr     out  ADDR_W  address the beat was read from
//  rsp_data     out  DATA_W  read data
//  busy         out  1       burst in progress (state != IDLE)
//  mem_read     out  1       to memory read
//  mem_write    out  1       to memory write
//  mem_addr     out  ADDR_W  to memory addr
//  mem_data_in  out  DATA_W  to memory data_in
//  mem_data_out in   DATA_W  from memory data_out (registered in memory)
// BEHAVIOUR
//  Reset (async assert, sync deassert): state IDLE; cmd_ready=1 after release; rsp_valid,
//   busy, mem_read, mem_write=0; mem_addr, mem_data_in, rsp_addr=0. Reset mid-burst aborts it;
//   no response is emitted for outstanding reads. Memory contents are untouched.
//  FSM states: IDLE, WRITE, READ, DRAIN.
//   IDLE : cmd_ready=1. On accept edge latch addr, len, seed; go WRITE or READ; beat cnt=0.
//   WRITE: mem_write=1, mem_read=0, mem_addr=start+cnt, mem_data_in=seed+cnt. One beat per
//          clock; after beat cnt==len go IDLE (mem_write drops the next cycle).
//   READ : mem_read=1, mem_write=0, mem_addr=start+cnt. After beat cnt==len go DRAIN.
//   DRAIN: one cycle, bus idle, last response emitted; then IDLE.
//  cmd_ready=0 in WRITE/READ/DRAIN; one command at a time; cmd inputs ignored while busy.
//  mem_read and mem_write are never both 1. All mem_* outputs are registered.
//  Address arithmetic is mod 2**ADDR_W: burst from 30 with len 3 hits 30,31,0,1.
//  Seed arithmetic is mod 2**DATA_W: seed 0xFE, 3 beats writes FE,FF,00.
//  Timing: accept at edge E; beat k is driven during the cycle after edge E+k; memory samples
//   it at edge E+k+1. For reads rsp_valid=1 in the cycle after edge E+k+1 with rsp_data =
//   mem_data_out and rsp_addr = address of beat k (one-cycle delayed copy of mem_addr).
//   Read-to-response latency = 1 cycle after the read beat; N-beat read occupies N+1 busy cycles.
//  rsp_valid is 0 for write bursts. A new command may be accepted in the first IDLE cycle;
//   the cycle after a WRITE beat is legal for a READ of the same address (memory updates
//   before the next edge).
// TESTING
//  1 Reset: assert rst_n=0 mid-read burst -> all outputs 0 immediately, no rsp_valid after release.
//  2 Write addr=3, len=0, wdata=0xA5 then read addr=3 len=0 -> one mem_write beat, then
//    rsp_valid one cycle after the read beat with rsp_addr=3, rsp_data=0xA5.
//  3 Burst write addr=0 len=31 seed=0x00, burst read addr=0 len=31 -> 32 responses, data==addr,
//    rsp_valid contiguous for 32 cycles, busy 33 cycles.
//  4 Wrap: write addr=30 len=3 seed=0xFE -> mem_addr 30,31,0,1 with data FE,FF,00,01; read back matches.
//  5 Backpressure: hold cmd_valid=1 with changing fields during a burst -> cmd_ready=0, fields
//    ignored; next command accepted only in IDLE.
//  6 Bus check every cycle: assertion mem_read && mem_write never true; mem_* stable within a beat.

Source files
------------

// File: rtl/mem_initiator.sv
// Bus initiator for a 2**ADDR_W x DATA_W synchronous memory: single/burst read and write
// commands come in on a valid/ready port, and read data goes out on a response port.
module mem_initiator #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    // Handshake: a command transfers on a posedge where cmd_valid && cmd_ready; cmd_ready is
    // high only in IDLE. The response port has no backpressure.
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_q;

    assign busy     = (state != IDLE);
    // The memory registers its output, so data lines up with the delayed read strobe.
    assign rsp_data = mem_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            len_q       <= '0;
            cmd_ready   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
        end else begin
            rsp_valid <= mem_read;
            if (mem_read)
                rsp_addr <= mem_addr;

            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        len_q     <= cmd_len;
                        cnt       <= '0;
                        mem_addr  <= cmd_addr;
                        if (cmd_write) begin
                            state       <= WRITE;
                            mem_write   <= 1'b1;
                            mem_data_in <= cmd_wdata;
                        end else begin
                            state    <= READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (cnt == len_q) begin
                        state     <= IDLE;
                        mem_write <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt         <= cnt + ADDR_W'(1);
                        mem_addr    <= mem_addr + ADDR_W'(1);
                        mem_data_in <= mem_data_in + DATA_W'(1);
                    end
                end
                READ: begin
                    if (cnt == len_q) begin
                        state    <= DRAIN;
                        mem_read <= 1'b0;
                    end else begin
                        cnt      <= cnt + ADDR_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
